// File: rtl/pokey_defs.sv
// ============================================================================
//  Package : pokey_defs
//  Purpose : Shared POKEY serial-port definitions. The transmitter and the
//            receiver both use the frame state encoding and the mark level.
//  Contents: IDLE/START/DATA/STOP state encodings, SOD_MARK line level,
//            tx_state_e enum built on those encodings.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pokey_defs;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   // Idle (mark) level of the serial line
   localparam logic SOD_MARK = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = IDLE,
      ST_START = START,
      ST_DATA  = DATA,
      ST_STOP  = STOP
   } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/pokey_serout_tx.sv
// ============================================================================
//  Module  : pokey_serout_tx
//  Purpose : POKEY SEROUT transmitter. CPU writes fill a holding register;
//            each bit_tick step (ce & bit_tick) sends one bit of the frame:
//            start bit, DATA_BITS data bits LSB first, STOP_BITS stop bits.
//            irq_need pulses on every holding-to-shifter transfer.
//  Ports   : clk, reset_n (async, active low), ce, bit_tick, wr_en, wr_data,
//            force_break (only with TX_BREAK_EN), sod, busy, hold_full,
//            irq_need, tx_done.
//  Config  : define TX_BREAK_EN to add force_break, which drives sod low
//            without disturbing the frame sequencer.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pokey_serout_tx
   import pokey_defs::*;
#(
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 ce,
   input  logic                 bit_tick,
   input  logic                 wr_en,
   input  logic [DATA_BITS-1:0] wr_data,
`ifdef TX_BREAK_EN
   input  logic                 force_break,
`endif
   output logic                 sod,
   output logic                 busy,
   output logic                 hold_full,
   output logic                 irq_need,
   output logic                 tx_done
);

   localparam logic [3:0] C_DATA_BITS = 4'(DATA_BITS);
   localparam logic [1:0] C_STOP_BITS = 2'(STOP_BITS);

   tx_state_e            state_q,     state_d;
   logic [DATA_BITS-1:0] hold_q,      hold_d;
   logic [DATA_BITS-1:0] shifter_q,   shifter_d;
   logic [3:0]           bit_cnt_q,   bit_cnt_d;
   logic [1:0]           stop_cnt_q,  stop_cnt_d;
   logic                 hold_full_q, hold_full_d;
   logic                 irq_q,       irq_d;
   logic                 sod_q,       sod_d;
   logic                 busy_q,      busy_d;
   logic                 done_q,      done_d;

   logic                 w_step;
   logic [DATA_BITS-1:0] w_shifted;

   assign w_step    = ce & bit_tick;
   assign w_shifted = shifter_q >> 1;

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      shifter_d   = shifter_q;
      bit_cnt_d   = bit_cnt_q;
      stop_cnt_d  = stop_cnt_q;
      hold_full_d = hold_full_q;
      irq_d       = irq_q;
      sod_d       = sod_q;

      if (ce) begin
         irq_d = 1'b0;
         if (wr_en) begin
            hold_d      = wr_data;
            hold_full_d = 1'b1;
         end
      end

      if (w_step) begin
         case (state_q)
            ST_IDLE: begin
               if (hold_full_q) begin
                  // Shifter takes the pre-write hold value; a same-cycle
                  // write keeps the holding register full.
                  state_d     = ST_START;
                  shifter_d   = hold_q;
                  hold_full_d = wr_en;
                  irq_d       = 1'b1;
                  sod_d       = 1'b0;
               end
            end
            ST_START: begin
               state_d   = ST_DATA;
               sod_d     = shifter_q[0];
               bit_cnt_d = 4'd1;
            end
            ST_DATA: begin
               if (bit_cnt_q < C_DATA_BITS) begin
                  shifter_d = w_shifted;
                  sod_d     = w_shifted[0];
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else begin
                  state_d    = ST_STOP;
                  sod_d      = SOD_MARK;
                  stop_cnt_d = 2'd1;
               end
            end
            default: begin // ST_STOP
               if (stop_cnt_q < C_STOP_BITS) begin
                  stop_cnt_d = stop_cnt_q + 2'd1;
               end else if (hold_full_q) begin
                  // Back-to-back frame: no idle step after the last stop bit
                  state_d     = ST_START;
                  shifter_d   = hold_q;
                  hold_full_d = wr_en;
                  irq_d       = 1'b1;
                  sod_d       = 1'b0;
               end else begin
                  state_d = ST_IDLE;
                  sod_d   = SOD_MARK;
               end
            end
         endcase
      end

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_IDLE) && !hold_full_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         hold_q      <= '0;
         shifter_q   <= '0;
         bit_cnt_q   <= 4'd0;
         stop_cnt_q  <= 2'd0;
         hold_full_q <= 1'b0;
         irq_q       <= 1'b0;
         sod_q       <= SOD_MARK;
         busy_q      <= 1'b0;
         done_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         shifter_q   <= shifter_d;
         bit_cnt_q   <= bit_cnt_d;
         stop_cnt_q  <= stop_cnt_d;
         hold_full_q <= hold_full_d;
         irq_q       <= irq_d;
         sod_q       <= sod_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

`ifdef TX_BREAK_EN
   // Break overrides the line only; the sequencer keeps its schedule
   assign sod = sod_q & ~force_break;
`else
   assign sod = sod_q;
`endif

   assign busy      = busy_q;
   assign hold_full = hold_full_q;
   assign irq_need  = irq_q;
   assign tx_done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_pokey_serout_tx.sv
// ============================================================================
//  Module  : tb_pokey_serout_tx
//  Purpose : Self-checking bench for pokey_serout_tx. A frame-queue model
//            predicts every output each cycle; directed tests add literal
//            expectations for the line waveform and interrupt counts.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pokey_serout_tx;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ce = 1'b0;
   logic       bit_tick = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       force_break = 1'b0;
   logic       sod, busy, hold_full, irq_need, tx_done;

   int total = 0;
   int bad   = 0;
   int irq_cnt = 0;
   logic irq_prev = 1'b0;

   always #5 clk = ~clk;

   pokey_serout_tx #(.DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ce         (ce),
      .bit_tick   (bit_tick),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
`ifdef TX_BREAK_EN
      .force_break(force_break),
`endif
      .sod        (sod),
      .busy       (busy),
      .hold_full  (hold_full),
      .irq_need   (irq_need),
      .tx_done    (tx_done)
   );

   // ---------------- behavioural model: queue of pending line bits ---------
   logic m_sod = 1'b1, m_busy = 1'b0, m_full = 1'b0, m_irq = 1'b0;
   logic [7:0] m_hold = 8'h00;
   logic m_q[$];

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_q.delete();
         m_sod = 1'b1; m_busy = 1'b0; m_full = 1'b0; m_irq = 1'b0; m_hold = 8'h00;
      end else if (ce) begin
         m_irq = 1'b0;
         if (bit_tick) begin
            if (m_q.size() > 0) begin
               m_sod = m_q.pop_front();
            end else if (m_full) begin
               m_q.push_back(1'b0);
               for (int i = 0; i < DATA_BITS; i++) m_q.push_back(m_hold[i]);
               for (int i = 0; i < STOP_BITS; i++) m_q.push_back(1'b1);
               m_sod  = m_q.pop_front();
               m_full = 1'b0;
               m_busy = 1'b1;
               m_irq  = 1'b1;
            end else begin
               m_sod  = 1'b1;
               m_busy = 1'b0;
            end
         end
         if (wr_en) begin
            m_hold = wr_data;
            m_full = 1'b1;
         end
      end
   end

   function automatic logic exp_sod();
`ifdef TX_BREAK_EN
      return m_sod & ~force_break;
`else
      return m_sod;
`endif
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      chk("cyc_sod",       {7'd0, sod},       {7'd0, exp_sod()});
      chk("cyc_busy",      {7'd0, busy},      {7'd0, m_busy});
      chk("cyc_hold_full", {7'd0, hold_full}, {7'd0, m_full});
      chk("cyc_irq",       {7'd0, irq_need},  {7'd0, m_irq});
      chk("cyc_tx_done",   {7'd0, tx_done},   {7'd0, !m_busy && !m_full});
      if (irq_need && !irq_prev) irq_cnt++;
      irq_prev = irq_need;
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input logic c, input logic t, input logic w, input logic [7:0] d);
      ce = c; bit_tick = t; wr_en = w; wr_data = d;
      @(posedge clk); #2;
      ce = 1'b0; bit_tick = 1'b0; wr_en = 1'b0;
   endtask

   task automatic step();
      cyc(1'b1, 1'b1, 1'b0, 8'h00);
   endtask

   task automatic wr(input logic [7:0] d);
      cyc(1'b1, 1'b0, 1'b1, d);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] exp2;
      logic [7:0] rx;
      int irq0;
      exp2 = 10'b11_0100_1010; // index i = line level after step i+1 for 8'hA5

      repeat (3) @(posedge clk);
      #2;
      chk("reset_sod",  {7'd0, sod},     8'd1);
      chk("reset_done", {7'd0, tx_done}, 8'd1);
      chk("reset_busy", {7'd0, busy},    8'd0);
      reset_n = 1'b1;
      @(posedge clk); #2;

      // Test 1: idle line
      for (int i = 0; i < 20; i++) begin
         step();
         chk("t1_sod", {7'd0, sod}, 8'd1);
      end
      chk("t1_done", {7'd0, tx_done}, 8'd1);
      chk("t1_irq_cnt", 8'(irq_cnt), 8'd0);

      // Test 2: single frame 8'hA5
      irq0 = irq_cnt;
      wr(8'hA5);
      chk("t2_done_after_wr", {7'd0, tx_done}, 8'd0);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("t2_sod_seq", {7'd0, sod}, {7'd0, exp2[i]});
      end
      step();
      chk("t2_done", {7'd0, tx_done}, 8'd1);
      chk("t2_busy", {7'd0, busy},    8'd0);
      chk("t2_irq_cnt", 8'(irq_cnt - irq0), 8'd1);

      // Test 3: back-to-back 8'h01 then 8'hFF
      irq0 = irq_cnt;
      wr(8'h01);
      step(); step(); step();
      wr(8'hFF);
      for (int i = 0; i < 6; i++) step();
      step();
      chk("t3_stop", {7'd0, sod}, 8'd1);
      step();
      chk("t3_start2", {7'd0, sod}, 8'd0);
      chk("t3_busy2", {7'd0, busy}, 8'd1);
      for (int i = 0; i < 10; i++) step();
      chk("t3_done", {7'd0, tx_done}, 8'd1);
      chk("t3_irq_cnt", 8'(irq_cnt - irq0), 8'd2);

      // Test 4: last write wins
      irq0 = irq_cnt;
      wr(8'h11);
      wr(8'h22);
      step();
      chk("t4_start", {7'd0, sod}, 8'd0);
      rx = 8'h00;
      for (int i = 0; i < 8; i++) begin
         step();
         rx[i] = sod;
      end
      chk("t4_byte", rx, 8'h22);
      step();
      step();
      chk("t4_irq_cnt", 8'(irq_cnt - irq0), 8'd1);
      chk("t4_done", {7'd0, tx_done}, 8'd1);

      // Test 5: async reset mid-DATA with ce low
      wr(8'hA5);
      for (int i = 0; i < 4; i++) step();
      chk("t5_busy_pre", {7'd0, busy}, 8'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("t5_sod",  {7'd0, sod},       8'd1);
      chk("t5_busy", {7'd0, busy},      8'd0);
      chk("t5_full", {7'd0, hold_full}, 8'd0);
      @(posedge clk); #2;
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("t5_idle_sod", {7'd0, sod}, 8'd1);
      end

`ifdef TX_BREAK_EN
      // Test 6: break during a frame of 8'hFF
      wr(8'hFF);
      step();
      force_break = 1'b1;
      #1;
      chk("t6_brk_start", {7'd0, sod}, 8'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t6_brk", {7'd0, sod}, 8'd0);
      end
      force_break = 1'b0;
      #1;
      chk("t6_release", {7'd0, sod}, 8'd1);
      for (int i = 0; i < 5; i++) step();
      chk("t6_stop", {7'd0, sod}, 8'd1);
      chk("t6_busy", {7'd0, busy}, 8'd1);
      step();
      chk("t6_end", {7'd0, busy}, 8'd0);
`endif

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
